// File: rtl/ext_mem_arbiter.sv
// Two-requester round-robin front end for the single-port external key-value memory.
// Each operation is issued for one cycle, its registered result captured, then returned on the owner's response channel.
module ext_mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int VALUE_SIZE   = 32,
  parameter int EXT_MEM_SIZE = 2048,
  localparam int CW          = $clog2(EXT_MEM_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_op,
  input  logic [WIDTH-1:0]      req0_key,
  input  logic [VALUE_SIZE-1:0] req0_value,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_op,
  input  logic [WIDTH-1:0]      req1_key,
  input  logic [VALUE_SIZE-1:0] req1_value,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [VALUE_SIZE-1:0] rsp0_value,
  output logic                  rsp0_hit,
  output logic                  rsp0_success,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [VALUE_SIZE-1:0] rsp1_value,
  output logic                  rsp1_hit,
  output logic                  rsp1_success,
  output logic [1:0]            mem_operation,
  output logic [WIDTH-1:0]      mem_key,
  output logic [VALUE_SIZE-1:0] mem_value_in,
  input  logic [VALUE_SIZE-1:0] mem_value_out,
  input  logic                  mem_hit,
  input  logic                  mem_success,
  output logic [CW-1:0]         entry_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [1:0] OP_LOOKUP  = 2'b00;
  localparam logic [1:0] OP_INSERT  = 2'b01;
  localparam logic [1:0] OP_DELETE  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  state_t                state_q, state_d;
  logic                  last_q;
  logic                  id_q;
  logic [1:0]            op_q;
  logic [WIDTH-1:0]      key_q;
  logic [VALUE_SIZE-1:0] val_q;
  logic [VALUE_SIZE-1:0] rsp_value_q;
  logic                  rsp_hit_q;
  logic                  rsp_success_q;
  logic [CW-1:0]         cnt_q;

  logic                  sel;
  logic                  accept;
  logic                  short_cut;
  logic                  rsp_take;
  logic [1:0]            sel_op;
  logic [WIDTH-1:0]      sel_key;
  logic [VALUE_SIZE-1:0] sel_value;

  // On a tie the requester that was not served last wins.
  assign sel       = req1_valid & (~req0_valid | ~last_q);
  assign accept    = (state_q == IDLE) & (req0_valid | req1_valid) & ~reset;
  assign sel_op    = sel ? req1_op : req0_op;
  assign sel_key   = sel ? req1_key : req0_key;
  assign sel_value = sel ? req1_value : req0_value;
  assign rsp_take  = id_q ? rsp1_ready : rsp0_ready;

  // Outcomes decidable from the entry count alone never touch the memory.
  assign short_cut = (sel_op == OP_ILLEGAL)
                   | ((sel_op == OP_INSERT) & (cnt_q == CW'(EXT_MEM_SIZE)))
                   | (((sel_op == OP_LOOKUP) | (sel_op == OP_DELETE)) & (cnt_q == '0));

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept & sel;

  assign mem_operation = (state_q == ISSUE) ? op_q : OP_ILLEGAL;
  assign mem_key       = key_q;
  assign mem_value_in  = val_q;
  assign entry_count   = cnt_q;
  assign busy          = (state_q != IDLE);

  assign rsp0_valid   = (state_q == RESP) & ~id_q;
  assign rsp0_value   = rsp0_valid ? rsp_value_q : '0;
  assign rsp0_hit     = rsp0_valid & rsp_hit_q;
  assign rsp0_success = rsp0_valid & rsp_success_q;
  assign rsp1_valid   = (state_q == RESP) & id_q;
  assign rsp1_value   = rsp1_valid ? rsp_value_q : '0;
  assign rsp1_hit     = rsp1_valid & rsp_hit_q;
  assign rsp1_success = rsp1_valid & rsp_success_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = short_cut ? RESP : ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      id_q          <= 1'b0;
      op_q          <= OP_ILLEGAL;
      key_q         <= '0;
      val_q         <= '0;
      rsp_value_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_success_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= sel;
        id_q   <= sel;
        op_q   <= sel_op;
        key_q  <= sel_key;
        val_q  <= sel_value;
        if (short_cut) begin
          rsp_value_q   <= '0;
          rsp_hit_q     <= 1'b0;
          rsp_success_q <= 1'b0;
        end
      end
      // Memory outputs were registered at the end of ISSUE and are valid now.
      if (state_q == CAPTURE) begin
        if (op_q == OP_LOOKUP) begin
          rsp_hit_q     <= mem_hit;
          rsp_success_q <= mem_hit;
          rsp_value_q   <= mem_hit ? mem_value_out : '0;
        end else begin
          rsp_hit_q     <= 1'b0;
          rsp_success_q <= mem_success;
          rsp_value_q   <= '0;
        end
        if (mem_success && op_q == OP_INSERT) cnt_q <= cnt_q + CW'(1);
        if (mem_success && op_q == OP_DELETE) cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: behavioural memory stub, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ext_mem_arbiter;
  localparam int W  = 16;
  localparam int V  = 16;
  localparam int SZ = 4;
  localparam int CW = $clog2(SZ + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]         req_valid = '0;
  logic [1:0][1:0]    req_op = '0;
  logic [1:0][W-1:0]  req_key = '0;
  logic [1:0][V-1:0]  req_value = '0;
  logic [1:0]         rsp_ready = 2'b11;
  wire  [1:0]         req_ready;
  wire  [1:0]         rsp_valid;
  wire  [1:0][V-1:0]  rsp_value;
  wire  [1:0]         rsp_hit;
  wire  [1:0]         rsp_success;
  wire  [1:0]         mem_operation;
  wire  [W-1:0]       mem_key;
  wire  [V-1:0]       mem_value_in;
  logic [V-1:0]       mem_value_out = '0;
  logic               mem_hit = 1'b0;
  logic               mem_success = 1'b0;
  wire  [CW-1:0]      entry_count;
  wire                busy;

  int n_cmp = 0;
  int n_bad = 0;

  ext_mem_arbiter #(.WIDTH(W), .VALUE_SIZE(V), .EXT_MEM_SIZE(SZ)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_key(req_key[0]), .req0_value(req_value[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_key(req_key[1]), .req1_value(req_value[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_value(rsp_value[0]),
    .rsp0_hit(rsp_hit[0]), .rsp0_success(rsp_success[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_value(rsp_value[1]),
    .rsp1_hit(rsp_hit[1]), .rsp1_success(rsp_success[1]),
    .mem_operation(mem_operation), .mem_key(mem_key), .mem_value_in(mem_value_in),
    .mem_value_out(mem_value_out), .mem_hit(mem_hit), .mem_success(mem_success),
    .entry_count(entry_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- external memory stub ----------------
  logic [W-1:0] s_keys[$];
  logic [V-1:0] s_vals[$];

  function automatic int sfind(input logic [W-1:0] k);
    for (int i = 0; i < s_keys.size(); i++) if (s_keys[i] == k) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      s_keys.delete();
      s_vals.delete();
      mem_value_out <= '0;
      mem_hit       <= 1'b0;
      mem_success   <= 1'b0;
    end else begin
      case (mem_operation)
        2'b00: begin
          if (sfind(mem_key) >= 0) begin
            mem_hit <= 1'b1; mem_success <= 1'b1; mem_value_out <= s_vals[sfind(mem_key)];
          end else begin
            mem_hit <= 1'b0; mem_success <= 1'b0; mem_value_out <= '0;
          end
        end
        2'b01: begin
          if (s_keys.size() < SZ) begin
            s_keys.push_back(mem_key); s_vals.push_back(mem_value_in); mem_success <= 1'b1;
          end else mem_success <= 1'b0;
        end
        2'b10: begin
          if (sfind(mem_key) >= 0) begin
            s_vals.delete(sfind(mem_key)); s_keys.delete(sfind(mem_key)); mem_success <= 1'b1;
          end else mem_success <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [W-1:0] m_keys[$];
  logic [V-1:0] m_vals[$];
  bit           m_pend = 0;
  int           m_own, m_issue, m_resp, m_cnt = 0, m_cnt_old = 0, m_last = 1, cyc = 0;
  bit           m_mem;
  logic [1:0]   m_op;
  logic [W-1:0] m_key;
  logic [V-1:0] m_val, e_val;
  logic         e_hit, e_suc;

  function automatic int mfind(input logic [W-1:0] k);
    for (int i = 0; i < m_keys.size(); i++) if (m_keys[i] == k) return i;
    return -1;
  endfunction

  initial begin : compare
    logic [1:0] exp_rdy;
    int w, idx;
    bit v;
    forever begin
      @(negedge clk);
      exp_rdy = '0;
      w = (req_valid == 2'b11) ? ((m_last == 1) ? 0 : 1) : (req_valid[1] ? 1 : 0);
      if (!m_pend && !reset && req_valid != 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      for (int n = 0; n < 2; n++) begin
        v = m_pend && (m_own == n) && (cyc >= m_resp);
        chk($sformatf("rsp%0d_valid", n), rsp_valid[n], v);
        chk($sformatf("rsp%0d_value", n), rsp_value[n], v ? e_val : '0);
        chk($sformatf("rsp%0d_hit", n), rsp_hit[n], v & e_hit);
        chk($sformatf("rsp%0d_success", n), rsp_success[n], v & e_suc);
      end
      if (m_pend && m_mem && cyc == m_issue) begin
        chk("mem_operation", mem_operation, m_op);
        chk("mem_key", mem_key, m_key);
        chk("mem_value_in", mem_value_in, m_val);
      end else chk("mem_operation_idle", mem_operation, 2'b11);
      chk("entry_count", entry_count, (m_pend && m_mem && cyc < m_resp) ? m_cnt_old : m_cnt);
      chk("busy", busy, m_pend);
      // decide what the coming clock edge does
      if (reset) begin
        m_pend = 0; m_cnt = 0; m_last = 1; m_keys.delete(); m_vals.delete();
      end else if (m_pend) begin
        if (cyc >= m_resp && rsp_ready[m_own]) m_pend = 0;
      end else if (req_valid != 0) begin
        m_pend = 1; m_own = w; m_last = w;
        m_op = req_op[w]; m_key = req_key[w]; m_val = req_value[w];
        e_val = '0; e_hit = 0; e_suc = 0;
        if (m_op == 2'b11 || (m_op == 2'b01 && m_cnt == SZ) ||
            (m_op != 2'b01 && m_cnt == 0)) begin
          m_mem = 0; m_resp = cyc + 1;
        end else begin
          m_mem = 1; m_issue = cyc + 1; m_resp = cyc + 3; m_cnt_old = m_cnt;
          idx = mfind(m_key);
          if (m_op == 2'b00) begin
            e_hit = (idx >= 0); e_suc = e_hit;
            if (idx >= 0) e_val = m_vals[idx];
          end else if (m_op == 2'b01) begin
            m_keys.push_back(m_key); m_vals.push_back(m_val); m_cnt++; e_suc = 1;
          end else if (idx >= 0) begin
            m_keys.delete(idx); m_vals.delete(idx); m_cnt--; e_suc = 1;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_op(input int n, input logic [1:0] op, input logic [W-1:0] k,
                       input logic [V-1:0] val, output logic [V-1:0] rv, output logic rh,
                       output logic rs, output int lat, output int mc, output logic [1:0] mop);
    int t;
    req_op[n] = op; req_key[n] = k; req_value[n] = val; req_valid[n] = 1'b1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready[n]) break;
    end
    if (t == 40) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[n] = 1'b0;
    rv = '0; rh = 0; rs = 0; lat = 0; mc = 0; mop = 2'b11;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      lat++;
      if (mem_operation != 2'b11) begin mc++; mop = mem_operation; end
      if (rsp_valid[n]) begin rv = rsp_value[n]; rh = rsp_hit[n]; rs = rsp_success[n]; break; end
    end
    if (t == 40) chk("response_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [V-1:0] rv, held;
    logic rh, rs;
    logic [1:0] mop, acc;
    int lat, mc, ng, nk, x, t, r;
    int g[4];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_operation", mem_operation, 2'b11);
    chk("reset_mem_key", mem_key, 0);
    chk("reset_mem_value_in", mem_value_in, 0);
    chk("reset_entry_count", entry_count, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    reset = 1'b0;

    do_op(0, 2'b01, 16'h10, 16'hAA, rv, rh, rs, lat, mc, mop);
    chk("ins_mem_cycles", mc, 1);
    chk("ins_mem_op", mop, 2'b01);
    chk("ins_success", rs, 1);
    chk("ins_hit", rh, 0);
    chk("ins_latency", lat, 3);
    chk("ins_count", entry_count, 1);

    do_op(1, 2'b00, 16'h10, 16'h0, rv, rh, rs, lat, mc, mop);
    chk("lkp_hit", rh, 1);
    chk("lkp_success", rs, 1);
    chk("lkp_value", rv, 16'hAA);
    do_op(1, 2'b00, 16'h20, 16'h0, rv, rh, rs, lat, mc, mop);
    chk("lkp_miss_hit", rh, 0);
    chk("lkp_miss_value", rv, 0);

    do_op(0, 2'b10, 16'h10, 16'h0, rv, rh, rs, lat, mc, mop);
    chk("del_success", rs, 1);
    chk("del_count", entry_count, 0);
    do_op(0, 2'b10, 16'h10, 16'h0, rv, rh, rs, lat, mc, mop);
    chk("del_empty_success", rs, 0);
    chk("del_empty_latency", lat, 1);
    chk("del_empty_mem_cycles", mc, 0);
    do_op(1, 2'b11, 16'h10, 16'h5, rv, rh, rs, lat, mc, mop);
    chk("illegal_fields", {rv, rh, rs}, 0);
    chk("illegal_latency", lat, 1);
    chk("illegal_mem_cycles", mc, 0);
    do_op(0, 2'b00, 16'h10, 16'h0, rv, rh, rs, lat, mc, mop);
    chk("lkp_empty_fields", {rv, rh, rs}, 0);
    chk("lkp_empty_latency", lat, 1);

    // Both requesters inserting continuously: grants must alternate starting at req0.
    do_reset();
    req_op[0] = 2'b01; req_key[0] = 16'h30; req_value[0] = 16'h130;
    req_op[1] = 2'b01; req_key[1] = 16'h31; req_value[1] = 16'h131;
    req_valid = 2'b11;
    ng = 0; nk = 2;
    for (t = 0; t < 80 && ng < 4; t++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        x = req_ready[1] ? 1 : 0;
        g[ng] = x; ng++;
        @(posedge clk); #1;
        req_key[x] = W'(16'h30 + nk); req_value[x] = V'(16'h130 + nk); nk++;
        if (ng == 4) req_valid = 2'b00;
      end
    end
    if (ng != 4) chk("alt_grant_timeout", ng, 4);
    for (t = 0; t < 20 && busy; t++) begin @(posedge clk); #1; end
    chk("alt_grant0", g[0], 0);
    chk("alt_grant1", g[1], 1);
    chk("alt_grant2", g[2], 0);
    chk("alt_grant3", g[3], 1);
    chk("full_count", entry_count, 4);
    do_op(0, 2'b01, 16'h50, 16'h150, rv, rh, rs, lat, mc, mop);
    chk("full_ins_success", rs, 0);
    chk("full_ins_latency", lat, 1);
    chk("full_ins_count", entry_count, 4);

    // Response held off for several cycles while the other requester waits.
    rsp_ready[0] = 1'b0;
    req_op[0] = 2'b00; req_key[0] = 16'h30; req_valid[0] = 1'b1;
    for (t = 0; t < 20; t++) begin @(negedge clk); if (req_ready[0]) break; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_op[1] = 2'b00; req_key[1] = 16'h31; req_valid[1] = 1'b1;
    for (t = 0; t < 20; t++) begin @(negedge clk); if (rsp_valid[0]) break; end
    held = rsp_value[0];
    chk("hold_value", held, 16'h130);
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp0_valid", rsp_valid[0], 1);
      chk("hold_rsp0_value", rsp_value[0], held);
      chk("hold_req1_ready", req_ready[1], 0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    for (t = 0; t < 20; t++) begin @(negedge clk); if (req_ready[1]) break; end
    if (t == 20) chk("hold_req1_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (t = 0; t < 20 && busy; t++) begin @(posedge clk); #1; end

    // Reset while the lookup sits in CAPTURE.
    req_op[0] = 2'b00; req_key[0] = 16'h31; req_valid[0] = 1'b1;
    for (t = 0; t < 20; t++) begin @(negedge clk); if (req_ready[0]) break; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_capture_busy", busy, 0);
    chk("rst_capture_rsp_valid", rsp_valid, 0);
    chk("rst_capture_count", entry_count, 0);
    chk("rst_capture_mem_operation", mem_operation, 2'b11);
    reset = 1'b0;

    // Randomized traffic with random back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 249) == 0);
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) req_valid[n] = 1'b0;
        if (!req_valid[n] && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 19);
          req_op[n]    = (r < 7) ? 2'b00 : (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
          req_key[n]   = W'($urandom_range(0, 7));
          req_value[n] = V'($urandom);
          req_valid[n] = 1'b1;
        end
        rsp_ready[n] = ($urandom_range(0, 9) < 7);
      end
    end
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
